// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_e    receiver FSM state encoding
//   PRESC_8/16/32 supported oversample ratios (clocks per bit)
//   PAR_EVEN/ODD  encoding of the parity-type select
//   maj3          2-of-3 vote used when UART_RX_MAJORITY_EN is defined
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: serial line, frame configuration and received-byte outputs
// of the UART receiver.
//   master : drives RX_IN_RX / PRESCALE_RX / PAR_EN_RX / PAR_TYP_RX,
//            observes P_DATA_RX / DATA_VLD_RX / PAR_ERR_RX / STP_ERR_RX
//   slave  : the receiver core (opposite directions)
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
);

  logic                  RX_IN_RX;
  logic [PRESC_W-1:0]    PRESCALE_RX;
  logic                  PAR_EN_RX;
  logic                  PAR_TYP_RX;
  logic [DATA_WIDTH-1:0] P_DATA_RX;
  logic                  DATA_VLD_RX;
  logic                  PAR_ERR_RX;
  logic                  STP_ERR_RX;

  modport master (
    output RX_IN_RX, PRESCALE_RX, PAR_EN_RX, PAR_TYP_RX,
    input  P_DATA_RX, DATA_VLD_RX, PAR_ERR_RX, STP_ERR_RX
  );

  modport slave (
    input  RX_IN_RX, PRESCALE_RX, PAR_EN_RX, PAR_TYP_RX,
    output P_DATA_RX, DATA_VLD_RX, PAR_ERR_RX, STP_ERR_RX
  );

endinterface

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit timing and bit sampling for the UART receiver.
//   clk, rst   clock, asynchronous active-high reset
//   rx_in      synchronised serial line
//   run        high while the receiver is inside a frame (counters clear otherwise)
//   presc      latched clocks-per-bit for the current frame
//   samp_bit   sampled bit value, valid while samp_tick is high
//   samp_tick  bit decision strobe (S, or S+1 with majority voting)
//   bit_end    last clock of the current bit (edge_cnt == presc-1)
//   bit_cnt    bits completed in the current frame
// Build option: UART_RX_MAJORITY_EN votes over samples at S-1, S and S+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int BCW     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               run,
  input  logic [PRESC_W-1:0] presc,
  output logic               samp_bit,
  output logic               samp_tick,
  output logic               bit_end,
  output logic [BCW-1:0]     bit_cnt
);

  logic [PRESC_W-1:0] edge_cnt;
  logic [PRESC_W-1:0] presc_m1;
  logic [PRESC_W-1:0] samp_pt;

  assign presc_m1 = presc - PRESC_W'(1);
  assign samp_pt  = presc >> 1;
  assign bit_end  = run && (edge_cnt == presc_m1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!run) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BCW'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESC_W'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  logic s_mid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_early <= 1'b0;
      s_mid   <= 1'b0;
    end else if (run) begin
      if (edge_cnt == samp_pt - PRESC_W'(1)) s_early <= rx_in;
      if (edge_cnt == samp_pt)               s_mid   <= rx_in;
    end
  end

  // Third vote is the live line value at S+1, so the decision lands one cycle later.
  assign samp_tick = run && (edge_cnt == samp_pt + PRESC_W'(1));
  assign samp_bit  = maj3(s_early, s_mid, rx_in);
`else
  assign samp_tick = run && (edge_cnt == samp_pt);
  assign samp_bit  = rx_in;
`endif

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: UART receiver. Oversamples the synchronised serial line,
// deframes start / data (LSB first) / optional parity / stop, and delivers a
// byte with a one-cycle valid pulse plus parity and stop error pulses.
//   CLK_RX   clock (rising edge)
//   RST_RX   asynchronous active-high reset
//   rx_if    slave modport of uart_rx_core_if: line + config in, byte/flags out
// Build option: UART_RX_MAJORITY_EN (2-of-3 bit voting, see uart_rx_sampler).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RX_IDLE   | line idle, waiting for a falling edge; config latched on exit
// RX_START  | start bit; a 1 at the sample point is a glitch -> RX_IDLE
// RX_DATA   | DATA_WIDTH payload bits shifted in LSB first
// RX_PARITY | parity bit checked against the received payload
// RX_STOP   | stop bit; frame evaluated and reported at the sample point
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input logic           CLK_RX,
  input logic           RST_RX,
  uart_rx_core_if.slave rx_if
);

  localparam int BCW = $clog2(DATA_WIDTH + 4);

  rx_state_e state_q, state_d;

  logic [PRESC_W-1:0]    presc_q;
  logic [PRESC_W-1:0]    presc_in;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_bad_q;
  logic                  rx_prev_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  vld_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  logic                  run;
  logic                  start_det;
  logic                  par_exp;
  logic                  samp_bit;
  logic                  samp_tick;
  logic                  bit_end;
  logic [BCW-1:0]        bit_cnt;

  // Ratios below 4 leave no room for a mid-bit sample point; fall back to 8.
  assign presc_in = (rx_if.PRESCALE_RX < PRESC_W'(4)) ? PRESC_W'(PRESC_8) : rx_if.PRESCALE_RX;

  // Edge rather than level: after a stop error on a line stuck low, a new
  // frame is only accepted once the line has gone back to 1.
  assign start_det = rx_prev_q & ~rx_if.RX_IN_RX;
  assign run       = (state_q != RX_IDLE);
  assign par_exp   = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W),
    .BCW     (BCW)
  ) u_sampler (
    .clk       (CLK_RX),
    .rst       (RST_RX),
    .rx_in     (rx_if.RX_IN_RX),
    .run       (run),
    .presc     (presc_q),
    .samp_bit  (samp_bit),
    .samp_tick (samp_tick),
    .bit_end   (bit_end),
    .bit_cnt   (bit_cnt)
  );

  always_ff @(posedge CLK_RX or posedge RST_RX) begin
    if (RST_RX) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: begin
        if (start_det) state_d = RX_START;
      end
      RX_START: begin
        if (samp_tick && samp_bit) state_d = RX_IDLE;
        else if (bit_end)          state_d = RX_DATA;
      end
      RX_DATA: begin
        // bit_cnt includes the start bit, so the last payload bit ends at DATA_WIDTH.
        if (bit_end && (bit_cnt == BCW'(DATA_WIDTH)))
          state_d = par_en_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (bit_end) state_d = RX_STOP;
      end
      RX_STOP: begin
        // Leaving at the sample point frees the second half of the stop bit
        // for detecting a back-to-back start edge.
        if (samp_tick) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK_RX or posedge RST_RX) begin
    if (RST_RX) begin
      presc_q   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad_q <= 1'b0;
      rx_prev_q <= 1'b0;
      shift_q   <= '0;
      p_data_q  <= '0;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      rx_prev_q <= rx_if.RX_IN_RX;
      vld_q     <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (start_det) begin
            presc_q   <= presc_in;
            par_en_q  <= rx_if.PAR_EN_RX;
            par_typ_q <= rx_if.PAR_TYP_RX;
            par_bad_q <= 1'b0;
            shift_q   <= '0;
          end
        end
        RX_DATA: begin
          if (samp_tick) shift_q <= {samp_bit, shift_q[DATA_WIDTH-1:1]};
        end
        RX_PARITY: begin
          if (samp_tick) par_bad_q <= (samp_bit != par_exp);
        end
        RX_STOP: begin
          if (samp_tick) begin
            stp_err_q <= ~samp_bit;
            par_err_q <= par_en_q & par_bad_q;
            if (samp_bit && !(par_en_q && par_bad_q)) begin
              p_data_q <= shift_q;
              vld_q    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_if.P_DATA_RX   = p_data_q;
  assign rx_if.DATA_VLD_RX = vld_q;
  assign rx_if.PAR_ERR_RX  = par_err_q;
  assign rx_if.STP_ERR_RX  = stp_err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
module tb_uart_rx_core;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_rx_core_if #(.DATA_WIDTH(8), .PRESC_W(6)) u_if ();

  uart_rx_core #(.DATA_WIDTH(8), .PRESC_W(6)) u_dut (
    .CLK_RX (clk),
    .RST_RX (rst),
    .rx_if  (u_if)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: counts every high cycle of each pulse and logs delivered bytes.
  int         vld_cnt  = 0;
  int         perr_cnt = 0;
  int         serr_cnt = 0;
  logic [7:0] vld_log [0:255];

  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.DATA_VLD_RX) begin
        vld_log[vld_cnt & 255] = u_if.P_DATA_RX;
        vld_cnt = vld_cnt + 1;
      end
      if (u_if.PAR_ERR_RX) perr_cnt = perr_cnt + 1;
      if (u_if.STP_ERR_RX) serr_cnt = serr_cnt + 1;
    end
  end

  // Reference: last byte that arrived in a good frame (0 after reset).
  logic [7:0] model_pdata = 8'h00;

  task automatic idle_cycles(input int n);
    u_if.RX_IN_RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v, input int p, input int glitch_k);
    for (int k = 0; k < p; k++) begin
      u_if.RX_IN_RX = (k == glitch_k) ? ~v : v;
      @(negedge clk);
    end
  endtask

  // Sends one frame at p clocks per bit (p_cfg is what goes on PRESCALE_RX),
  // then checks pulses and P_DATA_RX against the frame-level rules.
  task automatic send_frame(input string name, input logic [7:0] d, input int p_cfg, input int p,
                            input bit pen, input bit ptyp, input bit bad_par, input bit stop_v,
                            input int gap, input int glitch_bit, input bit scramble);
    int v0, pe0, se0;
    bit pbit, exp_vld, exp_perr, exp_serr;
    v0  = vld_cnt;
    pe0 = perr_cnt;
    se0 = serr_cnt;
    u_if.PRESCALE_RX = 6'(p_cfg);
    u_if.PAR_EN_RX   = pen;
    u_if.PAR_TYP_RX  = ptyp;
    u_if.RX_IN_RX    = 1'b0;
    @(negedge clk);
    if (scramble) begin
      u_if.PRESCALE_RX = 6'($urandom_range(2, 40));
      u_if.PAR_EN_RX   = 1'($urandom);
      u_if.PAR_TYP_RX  = 1'($urandom);
    end
    repeat (p - 1) @(negedge clk);
    for (int j = 0; j < 8; j++)
      drive_bit(d[j], p, (j == glitch_bit) ? (p / 2 + 1) : -1);
    if (pen) begin
      // Even: parity bit makes the total count of ones even; odd: makes it odd.
      pbit = (($countones(d) % 2) == 1);
      if (ptyp) pbit = !pbit;
      if (bad_par) pbit = !pbit;
      drive_bit(pbit, p, -1);
    end
    drive_bit(stop_v, p, -1);
    exp_serr = !stop_v;
    exp_perr = pen && bad_par;
    exp_vld  = !exp_serr && !exp_perr;
    if (exp_vld) model_pdata = d;
    check_val({name, ".vld"},  32'(vld_cnt - v0),   32'(exp_vld));
    check_val({name, ".perr"}, 32'(perr_cnt - pe0), 32'(exp_perr));
    check_val({name, ".serr"}, 32'(serr_cnt - se0), 32'(exp_serr));
    if (exp_vld && (vld_cnt > v0))
      check_val({name, ".byte"}, 32'(vld_log[(vld_cnt - 1) & 255]), 32'(d));
    check_val({name, ".pdata"}, 32'(u_if.P_DATA_RX), 32'(model_pdata));
    if (gap > 0) idle_cycles(gap);
  endtask

  task automatic check_quiet(input string name, input int v0, input int pe0, input int se0);
    check_val({name, ".vld"},  32'(vld_cnt - v0),   32'd0);
    check_val({name, ".perr"}, 32'(perr_cnt - pe0), 32'd0);
    check_val({name, ".serr"}, 32'(serr_cnt - se0), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, ".pdata"}, 32'(u_if.P_DATA_RX),   32'd0);
    check_val({name, ".vld"},   32'(u_if.DATA_VLD_RX), 32'd0);
    check_val({name, ".perr"},  32'(u_if.PAR_ERR_RX),  32'd0);
    check_val({name, ".serr"},  32'(u_if.STP_ERR_RX),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, pe0, se0;
    int p;
    logic [7:0] d;
    bit pen, bad, stp;

    rst              = 1'b1;
    u_if.RX_IN_RX    = 1'b1;
    u_if.PRESCALE_RX = 6'd8;
    u_if.PAR_EN_RX   = 1'b0;
    u_if.PAR_TYP_RX  = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle_cycles(5);

    send_frame("t1_a5", 8'hA5, 8, 8, 0, 0, 0, 1, 3, -1, 0);

    send_frame("t2_good", 8'h3C, 16, 16, 1, 0, 0, 1, 3, -1, 0);
    send_frame("t2_bad",  8'h3C, 16, 16, 1, 0, 1, 1, 3, -1, 0);

    send_frame("t3_stop", 8'h01, 32, 32, 1, 1, 0, 0, 3, -1, 0);
    send_frame("t3_7e",   8'h7E, 32, 32, 1, 1, 0, 1, 3, -1, 0);

    // Short low glitch: start bit rejected at its sample point.
    u_if.PRESCALE_RX = 6'd16;
    v0 = vld_cnt; pe0 = perr_cnt; se0 = serr_cnt;
    u_if.RX_IN_RX = 1'b0;
    repeat (4) @(negedge clk);
    idle_cycles(60);
    check_quiet("t4_glitch", v0, pe0, se0);
    send_frame("t4_after", 8'hC3, 16, 16, 0, 0, 0, 1, 2, -1, 0);

    send_frame("t5_55", 8'h55, 8, 8, 1, 0, 0, 1, 0, -1, 0);
    send_frame("t5_aa", 8'hAA, 8, 8, 1, 0, 0, 1, 0, -1, 0);
    idle_cycles(3);

    // Line stuck low: exactly one stop error, then silence until it returns high.
    u_if.PRESCALE_RX = 6'd8;
    u_if.PAR_EN_RX   = 1'b0;
    v0 = vld_cnt; pe0 = perr_cnt; se0 = serr_cnt;
    u_if.RX_IN_RX = 1'b0;
    repeat (300) @(negedge clk);
    check_val("stuck.serr", 32'(serr_cnt - se0), 32'd1);
    check_val("stuck.vld",  32'(vld_cnt - v0),   32'd0);
    check_val("stuck.perr", 32'(perr_cnt - pe0), 32'd0);
    idle_cycles(5);
    send_frame("stuck_after", 8'h96, 8, 8, 0, 0, 0, 1, 2, -1, 0);

    // PRESCALE below 4 runs at 8 clocks per bit.
    send_frame("presc2", 8'h4B, 2, 8, 0, 0, 0, 1, 2, -1, 0);

    // Reset during data bit 4.
    u_if.PRESCALE_RX = 6'd16;
    u_if.PAR_EN_RX   = 1'b0;
    u_if.RX_IN_RX    = 1'b0;
    repeat (16) @(negedge clk);
    d = 8'h5A;
    for (int j = 0; j < 4; j++) drive_bit(d[j], 16, -1);
    u_if.RX_IN_RX = d[4];
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    model_pdata = 8'h00;
    @(negedge clk);
    u_if.RX_IN_RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycles(10);
    send_frame("t6_0f", 8'h0F, 16, 16, 0, 0, 0, 1, 3, -1, 0);

`ifdef UART_RX_MAJORITY_EN
    send_frame("maj_glitch", 8'hB2, 16, 16, 0, 0, 0, 1, 3, 3, 0);
`endif

    // Random frames; configuration is scrambled after the start edge.
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 2))
        0:       p = 8;
        1:       p = 16;
        default: p = 32;
      endcase
      d   = 8'($urandom);
      pen = 1'($urandom);
      bad = pen && ($urandom_range(0, 3) == 0);
      stp = ($urandom_range(0, 4) != 0);
      send_frame($sformatf("rnd%0d", i), d, p, p, pen, 1'($urandom), bad, stp,
                 stp ? $urandom_range(0, 3) : $urandom_range(1, 4), -1, 1);
    end

    idle_cycles(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
